// File: rtl/vx_wb_pkg.sv
// Writeback sink shared types: beat bundle and width helpers.
// Optional perf counters in the top are enabled by WB_SINK_PERF_EN.
package vx_wb_pkg;

  function automatic int nw_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int nr_bits(input int n);
    return $clog2(n);
  endfunction

  localparam int WB_NUM_THREADS = 4;
  localparam int WB_NUM_WARPS   = 4;
  localparam int WB_NUM_REGS    = 64;
  localparam int WB_UUID_BITS   = 44;
  localparam int WB_NW_BITS     = nw_bits(WB_NUM_WARPS);
  localparam int WB_NR_BITS     = nr_bits(WB_NUM_REGS);

  typedef struct packed {
    logic [WB_UUID_BITS-1:0]     uuid;
    logic [WB_NUM_THREADS-1:0]   tmask;
    logic [WB_NW_BITS-1:0]       wid;
    logic [31:0]                 PC;
    logic [WB_NR_BITS-1:0]       rd;
    logic [WB_NUM_THREADS*32-1:0] data;
    logic                        eop;
  } wb_beat_t;

endpackage

// File: rtl/vx_wb_skid_buf.sv
// Two-register valid/ready buffer (output stage + skid) for writeback beats.
// in_ready depends only on registered state, never on out_pop.
module vx_wb_skid_buf
  import vx_wb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  input  wb_beat_t in_beat,
  output logic     in_ready,
  input  logic     out_pop,
  output logic     out_valid,
  output wb_beat_t out_beat
);

  logic     skid_valid;
  wb_beat_t skid_beat;
  logic     in_fire;

  assign in_ready = !skid_valid && !reset;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_beat   <= '0;
      skid_beat  <= '0;
    end else if (out_pop || !out_valid) begin
      // skid always drains first so FIFO order holds
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_beat   <= skid_beat;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire)
          out_beat <= in_beat;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_beat  <= in_beat;
    end
  end

endmodule

// File: rtl/vx_gpr_wb_sink.sv
// Writeback channel terminator: GPR write port and scoreboard release.
// Define WB_SINK_PERF_EN to add write/stall perf counters.
module vx_gpr_wb_sink
  import vx_wb_pkg::*;
#(
  parameter int NUM_THREADS = WB_NUM_THREADS,
  parameter int NUM_WARPS   = WB_NUM_WARPS,
  parameter int NUM_REGS    = WB_NUM_REGS,
  parameter int UUID_BITS   = WB_UUID_BITS,
  localparam int NW_BITS    = nw_bits(NUM_WARPS),
  localparam int NR_BITS    = nr_bits(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [UUID_BITS-1:0]     wb_uuid,
  input  logic [NUM_THREADS-1:0]   wb_tmask,
  input  logic [NW_BITS-1:0]       wb_wid,
  input  logic [31:0]              wb_PC,
  input  logic [NR_BITS-1:0]       wb_rd,
  input  logic [NUM_THREADS*32-1:0] wb_data,
  input  logic                     wb_eop,
  output logic                     wb_ready,
  output logic                     gpr_wr_valid,
  output logic [NW_BITS-1:0]       gpr_wr_wid,
  output logic [NR_BITS-1:0]       gpr_wr_rd,
  output logic [NUM_THREADS-1:0]   gpr_wr_tmask,
  output logic [NUM_THREADS*32-1:0] gpr_wr_data,
  input  logic                     gpr_wr_ready,
`ifdef WB_SINK_PERF_EN
  output logic [63:0]              perf_wb_writes,
  output logic [63:0]              perf_wb_stalls,
`endif
  output logic                     sb_release_valid,
  output logic [NW_BITS-1:0]       sb_release_wid,
  output logic [NR_BITS-1:0]       sb_release_rd
);

  wb_beat_t in_beat;
  wb_beat_t out_beat;
  logic     out_valid;
  logic     out_fire;
  logic     write_needed;
  logic     unused_trace;

  assign in_beat = '{
    uuid:  wb_uuid,
    tmask: wb_tmask,
    wid:   wb_wid,
    PC:    wb_PC,
    rd:    wb_rd,
    data:  wb_data,
    eop:   wb_eop
  };

  vx_wb_skid_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (wb_valid),
    .in_beat   (in_beat),
    .in_ready  (wb_ready),
    .out_pop   (out_fire),
    .out_valid (out_valid),
    .out_beat  (out_beat)
  );

  // index 0 is integer x0; fp regs sit above it so rd!=0 covers them
  assign write_needed = (out_beat.rd != '0) && (out_beat.tmask != '0);

  assign out_fire = out_valid && !reset &&
                    (gpr_wr_ready || !write_needed);

  assign gpr_wr_valid = out_valid && !reset && write_needed;
  assign gpr_wr_wid   = out_beat.wid;
  assign gpr_wr_rd    = out_beat.rd;
  assign gpr_wr_tmask = out_beat.tmask;
  assign gpr_wr_data  = out_beat.data;

  assign sb_release_valid = out_fire && out_beat.eop;
  assign sb_release_wid   = out_beat.wid;
  assign sb_release_rd    = out_beat.rd;

  assign unused_trace = ^{out_beat.uuid, out_beat.PC};

`ifdef WB_SINK_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_wb_writes <= '0;
      perf_wb_stalls <= '0;
    end else begin
      perf_wb_writes <= perf_wb_writes +
                        64'(gpr_wr_valid && gpr_wr_ready);
      perf_wb_stalls <= perf_wb_stalls +
                        64'(gpr_wr_valid && !gpr_wr_ready);
    end
  end
`endif

endmodule
